// File: rtl/peak_tracker_16b_if.sv
// Sample/result handshake bundle for peak_tracker_16b, including the operand
// and result wires of the neighbouring comparator_16b.
interface peak_tracker_16b_if;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] cmp_a;
    logic [15:0] cmp_b;
    logic        cmp_gt;
    logic        cmp_eq;
    logic        cmp_lt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_max;
    logic [15:0] out_min;
    logic [7:0]  out_max_cnt;

    modport slave (
        input  clr, in_valid, in_data, cmp_gt, cmp_eq, cmp_lt, out_ready,
        output in_ready, cmp_a, cmp_b, out_valid, out_max, out_min, out_max_cnt
    );

    modport master (
        output clr, in_valid, in_data, cmp_gt, cmp_eq, cmp_lt, out_ready,
        input  in_ready, cmp_a, cmp_b, out_valid, out_max, out_min, out_max_cnt
    );
endinterface

// File: rtl/peak_tracker_16b.sv
// Windowed max/min/max-count tracker; borrows an external comparator_16b for
// the max check and then the min check of every sample after the first.
//
// state   | meaning
// ACCEPT  | waiting for a sample (in_ready high)
// CMP_MAX | comparator sees samp vs max_r
// CMP_MIN | comparator sees samp vs min_r
// DONE    | window result presented until out_ready
module peak_tracker_16b #(
    parameter int unsigned WINDOW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    peak_tracker_16b_if.slave pt
);
    typedef enum logic [1:0] {ACCEPT, CMP_MAX, CMP_MIN, DONE} state_t;

    localparam logic [7:0] WIN = 8'(WINDOW);

    state_t      state_q, state_d;
    logic [15:0] samp_q, samp_d;
    logic [15:0] max_q, max_d;
    logic [15:0] min_q, min_d;
    logic [7:0]  max_cnt_q, max_cnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  cmp_res;

    assign cmp_res = {pt.cmp_gt, pt.cmp_eq, pt.cmp_lt};

    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        max_d     = max_q;
        min_d     = min_q;
        max_cnt_d = max_cnt_q;
        cnt_d     = cnt_q;
        if (pt.clr) begin
            // Everything else is left untouched; cnt == 0 forces a fresh window.
            cnt_d   = 8'd0;
            state_d = ACCEPT;
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (pt.in_valid) begin
                        samp_d = pt.in_data;
                        if (cnt_q == 8'd0) begin
                            max_d     = pt.in_data;
                            min_d     = pt.in_data;
                            max_cnt_d = 8'd1;
                            cnt_d     = 8'd1;
                            state_d   = (WIN == 8'd1) ? DONE : ACCEPT;
                        end else begin
                            cnt_d   = cnt_q + 8'd1;
                            state_d = CMP_MAX;
                        end
                    end
                end
                CMP_MAX: begin
                    case (cmp_res)
                        3'b100: begin
                            max_d     = samp_q;
                            max_cnt_d = 8'd1;
                        end
                        3'b010: begin
                            if (max_cnt_q != 8'hFF) max_cnt_d = max_cnt_q + 8'd1;
                        end
                        default: ;
                    endcase
                    state_d = CMP_MIN;
                end
                CMP_MIN: begin
                    if (cmp_res == 3'b001) min_d = samp_q;
                    state_d = (cnt_q == WIN) ? DONE : ACCEPT;
                end
                DONE: begin
                    if (pt.out_ready) begin
                        cnt_d   = 8'd0;
                        state_d = ACCEPT;
                    end
                end
                default: state_d = ACCEPT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCEPT;
            samp_q    <= 16'd0;
            max_q     <= 16'd0;
            min_q     <= 16'd0;
            max_cnt_q <= 8'd0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            samp_q    <= samp_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_cnt_q <= max_cnt_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pt.in_ready    = (state_q == ACCEPT);
    assign pt.out_valid   = (state_q == DONE);
    assign pt.cmp_a       = samp_q;
    assign pt.cmp_b       = (state_q == CMP_MIN) ? min_q : max_q;
    assign pt.out_max     = max_q;
    assign pt.out_min     = min_q;
    assign pt.out_max_cnt = max_cnt_q;
endmodule
